// File: rtl/hyperbus_responder.sv
// HyperBus device-side responder backed by a 16-bit-word RAM plus CR0.
// The bus is oversampled on i_clk: every bus signal passes two flops, and each
// change of the synced CK while synced CS# is low moves exactly one byte
// (rising edge = upper byte [15:8], falling edge = lower byte [7:0]).
//
// Ports:
//   i_clk, i_rst_l            system clock (>= 4x CK) and async active-low reset
//   hb_ck, hb_cs_l, hb_rst_l  bus clock, chip select, device reset (async inputs)
//   hb_dq_in/out, hb_dq_oe_l  DQ sample, drive value, active-low output enable
//   hb_rwds_in/out/oe_l       RWDS sample (write mask), drive value, enable
//   o_busy                    high whenever a transaction is in progress
module hyperbus_responder #(
  parameter int          ADDR_W    = 10,
  parameter int          LATENCY   = 6,
  parameter logic [15:0] CR0_RESET = 16'h8F1F,
  parameter logic [15:0] ID0_VALUE = 16'h0C81
) (
  input  logic       i_clk,
  input  logic       i_rst_l,
  input  logic       hb_ck,
  input  logic       hb_cs_l,
  input  logic       hb_rst_l,
  input  logic [7:0] hb_dq_in,
  output logic [7:0] hb_dq_out,
  output logic       hb_dq_oe_l,
  input  logic       hb_rwds_in,
  output logic       hb_rwds_out,
  output logic       hb_rwds_oe_l,
  output logic       o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_RD, S_WR, S_REG_WR} state_t;

  localparam logic [7:0] LAT_EDGES = 8'(2 * LATENCY);

  state_t              state, state_nxt;
  logic                ck_p0, ck_p1, ck_p2;
  logic                cs_p0, cs_p1, cs_p2;
  logic                hrst_p0, hrst_p1;
  logic                rwds_p0, rwds_p1;
  logic [7:0]          dq_p0, dq_p1;
  logic                evt, rise;
  logic [2:0]          cnt;
  logic [7:0]          lat_cnt;
  logic                byte_lo;
  logic                reg_done;
  logic [15:0]         cr0;
  logic [39:0]         ca_sr;
  logic                is_rd, is_reg, is_lin, reg_sel;
  logic [ADDR_W-1:0]   addr, addr_inc;
  logic [7:0]          wr_hi;
  logic                mask_hi;
  logic                we_hi, we_lo;
  logic                ca_last;
  logic [15:0]         rd_word;
  logic [15:0]         mem [2**ADDR_W];

  // stage p0/p1: two-flop synchronizers; p2 holds the previous synced value
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      ck_p0   <= 1'b0;
      ck_p1   <= 1'b0;
      ck_p2   <= 1'b0;
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      hrst_p0 <= 1'b0;
      hrst_p1 <= 1'b0;
    end else begin
      ck_p0   <= hb_ck;
      ck_p1   <= ck_p0;
      ck_p2   <= ck_p1;
      cs_p0   <= hb_cs_l;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      hrst_p0 <= hb_rst_l;
      hrst_p1 <= hrst_p0;
    end
  end

  always_ff @(posedge i_clk) begin
    dq_p0   <= hb_dq_in;
    dq_p1   <= dq_p0;
    rwds_p0 <= hb_rwds_in;
    rwds_p1 <= rwds_p0;
  end

  assign evt      = !cs_p1 && (ck_p1 != ck_p2);
  assign rise     = evt && ck_p1;
  assign ca_last  = (state == S_CA) && evt && (cnt == 3'd5);
  assign o_busy   = (state != S_IDLE);
  assign rd_word  = is_reg ? (reg_sel ? cr0 : ID0_VALUE) : mem[addr];
  // Wrapped bursts stay inside an aligned 16-word group.
  assign addr_inc = is_lin ? addr + ADDR_W'(1) : {addr[ADDR_W-1:4], addr[3:0] + 4'd1};

  always_comb begin
    state_nxt = state;
    if (!hrst_p1 || cs_p1) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (cs_p2) state_nxt = S_CA;
        // ca_sr holds CA bytes 1..5, so the final CA is {ca_sr, dq_p1}
        S_CA: if (ca_last) begin
          if (!ca_sr[39] && ca_sr[38]) state_nxt = S_REG_WR;
          else if (LATENCY > 0)        state_nxt = S_LAT;
          else                         state_nxt = ca_sr[39] ? S_RD : S_WR;
        end
        // Leave on the falling edge after the last latency rising edge so
        // the first data byte lands on a rising edge.
        S_LAT: if (evt && !ck_p1 && lat_cnt == LAT_EDGES)
          state_nxt = is_rd ? S_RD : S_WR;
        default: ;
      endcase
    end
  end

  // A lone upper byte left when CS# rises is still written.
  always_comb begin
    we_hi = 1'b0;
    we_lo = 1'b0;
    if (state == S_WR && hrst_p1 && byte_lo) begin
      if (evt) begin
        we_hi = !mask_hi;
        we_lo = !rwds_p1;
      end else if (cs_p1) begin
        we_hi = !mask_hi;
      end
    end
  end

  // stage: control state and bus drivers
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      state        <= S_IDLE;
      cnt          <= 3'd0;
      lat_cnt      <= 8'd0;
      byte_lo      <= 1'b0;
      reg_done     <= 1'b0;
      hb_dq_oe_l   <= 1'b1;
      hb_rwds_oe_l <= 1'b1;
      hb_dq_out    <= 8'h00;
      hb_rwds_out  <= 1'b0;
      cr0          <= CR0_RESET;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_IDLE) begin
        hb_dq_oe_l   <= 1'b1;
        hb_rwds_oe_l <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          cnt      <= 3'd0;
          lat_cnt  <= 8'd0;
          byte_lo  <= 1'b0;
          reg_done <= 1'b0;
          // RWDS high during CA advertises fixed double latency.
          if (state_nxt == S_CA) begin
            hb_rwds_oe_l <= 1'b0;
            hb_rwds_out  <= 1'b1;
          end
        end
        S_CA: if (evt) begin
          cnt <= cnt + 3'd1;
          if (ca_last) hb_rwds_oe_l <= 1'b1;
        end
        S_LAT: if (rise) lat_cnt <= lat_cnt + 8'd1;
        S_RD: if (evt) begin
          hb_dq_out   <= byte_lo ? rd_word[7:0] : rd_word[15:8];
          hb_rwds_out <= ~hb_rwds_out;
          byte_lo     <= ~byte_lo;
        end
        S_WR: if (evt) byte_lo <= ~byte_lo;
        S_REG_WR: if (evt && !reg_done) begin
          byte_lo <= ~byte_lo;
          if (byte_lo) begin
            reg_done <= 1'b1;
            if (reg_sel) cr0 <= {wr_hi, dq_p1};
          end
        end
        default: ;
      endcase
      // RWDS preset high so its first toggle marks the upper byte with 0.
      if (state_nxt == S_RD && state != S_RD) begin
        hb_dq_oe_l   <= 1'b0;
        hb_rwds_oe_l <= 1'b0;
        hb_rwds_out  <= 1'b1;
      end
      if (!hrst_p1) cr0 <= CR0_RESET;
    end
  end

  // stage: CA decode, address and write-byte datapath
  always_ff @(posedge i_clk) begin
    if (state == S_CA && evt) ca_sr <= {ca_sr[31:0], dq_p1};
    if (ca_last) begin
      is_rd   <= ca_sr[39];
      is_reg  <= ca_sr[38];
      is_lin  <= ca_sr[37];
      reg_sel <= dq_p1[0];
      addr    <= ADDR_W'({ca_sr[36:8], dq_p1[2:0]});
    end
    if ((state == S_RD || state == S_WR) && evt && byte_lo && !is_reg) addr <= addr_inc;
    if (evt && !byte_lo) begin
      wr_hi   <= dq_p1;
      mask_hi <= rwds_p1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (we_hi) mem[addr][15:8] <= wr_hi;
    if (we_lo) mem[addr][7:0]  <= dq_p1;
  end

endmodule
